// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 16-bit 8086-style ALU.
//   op_e    - operation codes presented on the op input
//   opfl_e  - flag-control codes presented on the opFL input
//   F_*     - bit positions inside the 8086-layout FLAGS register
package alu_pkg;

   typedef enum logic [5:0] {
      OP_ADD   = 6'h00,
      OP_OR    = 6'h01,
      OP_ADC   = 6'h02,
      OP_SBB   = 6'h03,
      OP_AND   = 6'h04,
      OP_SUB   = 6'h05,
      OP_XOR   = 6'h06,
      OP_CMP   = 6'h07,
      OP_ROL   = 6'h08,
      OP_ROR   = 6'h09,
      OP_RCL   = 6'h0A,
      OP_RCR   = 6'h0B,
      OP_SHL   = 6'h0C,
      OP_SHR   = 6'h0D,
      OP_SAL   = 6'h0E,
      OP_SAR   = 6'h0F,
      OP_MUL8  = 6'h20,
      OP_MUL16 = 6'h21,
      OP_NOT   = 6'h28,
      OP_NEG   = 6'h29,
      OP_CBW   = 6'h2C,
      OP_CWD   = 6'h2D
   } op_e;

   typedef enum logic [2:0] {
      FC_CLC = 3'd0,
      FC_STC = 3'd1,
      FC_CMC = 3'd2,
      FC_CLD = 3'd3,
      FC_STD = 3'd4,
      FC_CLI = 3'd5,
      FC_STI = 3'd6,
      FC_NOP = 3'd7
   } opfl_e;

   localparam int unsigned F_CF = 0;
   localparam int unsigned F_PF = 2;
   localparam int unsigned F_AF = 4;
   localparam int unsigned F_ZF = 6;
   localparam int unsigned F_SF = 7;
   localparam int unsigned F_TF = 8;
   localparam int unsigned F_IF = 9;
   localparam int unsigned F_DF = 10;
   localparam int unsigned F_OF = 11;

   // Bit 1 reads as 1; only the defined flag bits may ever be set.
   localparam logic [15:0] FLAGS_RESET = 16'h0002;
   localparam logic [15:0] FLAGS_MASK  = 16'h0FD7;

   // 8086 PF: set when the low byte holds an even number of ones.
   function automatic logic parity8(input logic [7:0] v);
      return ~^v;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational shift/rotate unit.
//   val    - operand to shift
//   cnt    - shift count (0..31); count 0 returns val unchanged
//   sel    - low three bits of the opcode: ROL,ROR,RCL,RCR,SHL,SHR,SAL,SAR
//   cf_in  - incoming carry (used by RCL/RCR and kept when cnt is 0)
//   res    - shifted result
//   cf     - last bit shifted out (through carry for RCL/RCR)
//   of     - overflow computed with the single-bit-shift rule
module alu_shifter
   import alu_pkg::*;
(
   input  logic [15:0] val,
   input  logic [4:0]  cnt,
   input  logic [2:0]  sel,
   input  logic        cf_in,
   output logic [15:0] res,
   output logic        cf,
   output logic        of
);

   // One bit position per iteration; iterations beyond cnt are no-ops.
   always_comb begin
      res = val;
      cf  = cf_in;
      for (int i = 0; i < 31; i++) begin
         if (i < int'(cnt)) begin
            case (sel)
               3'd0: begin cf = res[15]; res = {res[14:0], res[15]}; end
               3'd1: begin cf = res[0];  res = {res[0], res[15:1]};  end
               3'd2: {cf, res} = {res, cf};
               3'd3: {res, cf} = {cf, res};
               3'd4: begin cf = res[15]; res = {res[14:0], 1'b0};    end
               3'd5: begin cf = res[0];  res = {1'b0, res[15:1]};    end
               3'd6: begin cf = res[15]; res = {res[14:0], 1'b0};    end
               default: begin cf = res[0]; res = {res[15], res[15:1]}; end
            endcase
         end
      end
   end

   // Left operations: OF = new MSB xor CF. Right operations follow the
   // 8086 one-bit rules based on the original MSB (SAR never overflows).
   always_comb begin
      case (sel)
         3'd1:    of = res[15] ^ res[14];
         3'd3:    of = val[15] ^ cf_in;
         3'd5:    of = val[15];
         3'd7:    of = 1'b0;
         default: of = res[15] ^ cf;
      endcase
   end

endmodule

// File: rtl/alu.sv
// alu: 16-bit 8086-style arithmetic/logic unit.
//   CLK, RST      - clock (rising edge) and asynchronous active-low reset
//   A             - shared data bus for RA/RB/D loads
//   WA, WB        - level loads of RA / RB from A
//   WD            - level load of D; its rising edge also executes op
//   V             - shift count source (0: one, 1: D[4:0])
//   op            - operation code (alu_pkg::op_e)
//   ENADi, opFL   - rising edge applies a flag-control instruction
//   WR            - output select for R1/R2
//   R1, R2        - muxed outputs
//   FLAGS, FL, IF - full flag register, {OF,SF,ZF,AF,PF,CF}, FLAGS[9]
//   FINP          - one-cycle pulse after each execute edge
module alu
   import alu_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] A,
   input  logic        V,
   input  logic [5:0]  op,
   input  logic        WA,
   input  logic        WB,
   input  logic        WD,
   input  logic        ENADi,
   input  logic [1:0]  WR,
   input  logic [2:0]  opFL,
   output logic [15:0] R1,
   output logic [15:0] R2,
   output logic [15:0] FLAGS,
   output logic [5:0]  FL,
   output logic        FINP,
   output logic        IF
);

   logic [15:0] ra, rb, d, rl, rh, flags_r;
   logic        wd_q, ena_q, finp_r;
   logic        exec, fcexec;

   logic [15:0] rl_n, rh_n, fl_op, flags_ex, flags_n;
   logic        cin, bin;
   logic [16:0] sum, dif;
   logic [15:0] sub_a, sub_b;
   logic        af_add, of_add, af_sub, of_sub;
   logic [15:0] prod8;
   logic [31:0] prod16;
   logic [4:0]  cnt;
   logic [15:0] sh_res;
   logic        sh_cf, sh_of;
   op_e         opc;

   function automatic logic [15:0] set_status(input logic [15:0] f,
                                              input logic c,
                                              input logic a,
                                              input logic o,
                                              input logic [15:0] r);
      logic [15:0] n;
      n       = f;
      n[F_CF] = c;
      n[F_AF] = a;
      n[F_OF] = o;
      n[F_SF] = r[15];
      n[F_ZF] = (r == 16'h0000);
      n[F_PF] = parity8(r[7:0]);
      return n;
   endfunction

   function automatic logic [15:0] apply_fc(input logic [15:0] f,
                                            input logic [2:0] code);
      logic [15:0] n;
      n = f;
      case (opfl_e'(code))
         FC_CLC:  n[F_CF] = 1'b0;
         FC_STC:  n[F_CF] = 1'b1;
         FC_CMC:  n[F_CF] = ~f[F_CF];
         FC_CLD:  n[F_DF] = 1'b0;
         FC_STD:  n[F_DF] = 1'b1;
         FC_CLI:  n[F_IF] = 1'b0;
         FC_STI:  n[F_IF] = 1'b1;
         default: n = f;
      endcase
      return n;
   endfunction

   assign opc    = op_e'(op);
   assign exec   = WD & ~wd_q;
   assign fcexec = ENADi & ~ena_q;
   assign cnt    = V ? d[4:0] : 5'd1;

   // Adder: ADD/ADC.
   assign cin    = (opc == OP_ADC) ? flags_r[F_CF] : 1'b0;
   assign sum    = {1'b0, ra} + {1'b0, rb} + {16'h0000, cin};
   assign af_add = ra[4] ^ rb[4] ^ sum[4];
   assign of_add = (ra[15] == rb[15]) && (sum[15] != ra[15]);

   // Subtractor: SUB/SBB/CMP, and NEG as 0 - RA. Bit 16 is the borrow.
   assign sub_a  = (opc == OP_NEG) ? 16'h0000 : ra;
   assign sub_b  = (opc == OP_NEG) ? ra : rb;
   assign bin    = (opc == OP_SBB) ? flags_r[F_CF] : 1'b0;
   assign dif    = {1'b0, sub_a} - {1'b0, sub_b} - {16'h0000, bin};
   assign af_sub = sub_a[4] ^ sub_b[4] ^ dif[4];
   assign of_sub = (sub_a[15] != sub_b[15]) && (dif[15] != sub_a[15]);

   assign prod8  = {8'h00, ra[7:0]} * {8'h00, rb[7:0]};
   assign prod16 = {16'h0000, ra} * {16'h0000, rb};

   alu_shifter u_shifter (
      .val   (ra),
      .cnt   (cnt),
      .sel   (op[2:0]),
      .cf_in (flags_r[F_CF]),
      .res   (sh_res),
      .cf    (sh_cf),
      .of    (sh_of)
   );

   always_comb begin
      rl_n  = rl;
      rh_n  = 16'h0000;
      fl_op = flags_r;
      case (opc)
         OP_ADD, OP_ADC: begin
            rl_n  = sum[15:0];
            fl_op = set_status(flags_r, sum[16], af_add, of_add, sum[15:0]);
         end
         OP_SUB, OP_SBB, OP_NEG: begin
            rl_n  = dif[15:0];
            fl_op = set_status(flags_r, dif[16], af_sub, of_sub, dif[15:0]);
         end
         OP_CMP: begin
            fl_op = set_status(flags_r, dif[16], af_sub, of_sub, dif[15:0]);
         end
         OP_OR: begin
            rl_n  = ra | rb;
            fl_op = set_status(flags_r, 1'b0, 1'b0, 1'b0, ra | rb);
         end
         OP_AND: begin
            rl_n  = ra & rb;
            fl_op = set_status(flags_r, 1'b0, 1'b0, 1'b0, ra & rb);
         end
         OP_XOR: begin
            rl_n  = ra ^ rb;
            fl_op = set_status(flags_r, 1'b0, 1'b0, 1'b0, ra ^ rb);
         end
         OP_ROL, OP_ROR, OP_RCL, OP_RCR,
         OP_SHL, OP_SHR, OP_SAL, OP_SAR: begin
            // A zero count leaves RL and flags as they were.
            if (cnt != 5'd0) begin
               rl_n        = sh_res;
               fl_op[F_CF] = sh_cf;
               fl_op[F_OF] = sh_of;
               // op[2] distinguishes shifts (update SF/ZF/PF) from rotates.
               if (op[2]) begin
                  fl_op[F_SF] = sh_res[15];
                  fl_op[F_ZF] = (sh_res == 16'h0000);
                  fl_op[F_PF] = parity8(sh_res[7:0]);
               end
            end
         end
         OP_MUL8: begin
            rl_n  = prod8;
            fl_op = set_status(flags_r, |prod8[15:8], 1'b0, |prod8[15:8], prod8);
         end
         OP_MUL16: begin
            rl_n  = prod16[15:0];
            rh_n  = prod16[31:16];
            fl_op = set_status(flags_r, |prod16[31:16], 1'b0, |prod16[31:16],
                               prod16[15:0]);
         end
         OP_NOT: rl_n = ~ra;
         OP_CBW: rl_n = {{8{ra[7]}}, ra[7:0]};
         OP_CWD: begin
            rl_n = ra;
            rh_n = {16{ra[15]}};
         end
         default: begin
            rl_n = rl;
            rh_n = rh;
         end
      endcase
   end

   // Flag-control on the same edge as an execute applies on top of it.
   always_comb begin
      flags_ex = exec ? fl_op : flags_r;
      flags_n  = fcexec ? apply_fc(flags_ex, opFL) : flags_ex;
      flags_n  = (flags_n & FLAGS_MASK) | FLAGS_RESET;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ra      <= 16'h0000;
         rb      <= 16'h0000;
         d       <= 16'h0000;
         rl      <= 16'h0000;
         rh      <= 16'h0000;
         flags_r <= FLAGS_RESET;
         wd_q    <= 1'b0;
         ena_q   <= 1'b0;
         finp_r  <= 1'b0;
      end else begin
         wd_q    <= WD;
         ena_q   <= ENADi;
         finp_r  <= exec;
         flags_r <= flags_n;
         if (WA) ra <= A;
         if (WB) rb <= A;
         if (WD) d  <= A;
         if (exec) begin
            rl <= rl_n;
            rh <= rh_n;
         end
      end
   end

   always_comb begin
      case (WR)
         2'd0:    begin R1 = rl;      R2 = rh;       end
         2'd1:    begin R1 = ra;      R2 = rb;       end
         2'd2:    begin R1 = d;       R2 = 16'h0000; end
         default: begin R1 = flags_r; R2 = rl;       end
      endcase
   end

   assign FLAGS = flags_r;
   assign FL    = {flags_r[F_OF], flags_r[F_SF], flags_r[F_ZF],
                   flags_r[F_AF], flags_r[F_PF], flags_r[F_CF]};
   assign IF    = flags_r[F_IF];
   assign FINP  = finp_r;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu. Each execute pushes its expected
// R1/R2/FL into a queue; a monitor pops and compares whenever FINP is high.
module tb_alu;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] A = 16'h0000;
   logic        V = 1'b0;
   logic [5:0]  op = 6'h00;
   logic        WA = 1'b0, WB = 1'b0, WD = 1'b0, ENADi = 1'b0;
   logic [1:0]  WR = 2'd0;
   logic [2:0]  opFL = 3'd7;
   logic [15:0] R1, R2, FLAGS;
   logic [5:0]  FL;
   logic        FINP, IF;

   alu dut (
      .CLK(CLK), .RST(RST), .A(A), .V(V), .op(op), .WA(WA), .WB(WB),
      .WD(WD), .ENADi(ENADi), .WR(WR), .opFL(opFL), .R1(R1), .R2(R2),
      .FLAGS(FLAGS), .FL(FL), .FINP(FINP), .IF(IF)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [15:0] r1;
      logic [15:0] r2;
      logic [5:0]  fl;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected FLAGS from {OF,SF,ZF,AF,PF,CF} with DF/IF/TF clear.
   function automatic logic [15:0] fl2flags(input logic [5:0] f);
      return {4'b0000, f[5], 3'b000, f[4], f[3], 1'b0, f[2], 1'b0, f[1], 1'b1, f[0]};
   endfunction

   // Monitor: compare whenever the DUT signals a finished operation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (FINP) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected FINP: got 1, expected 0");
            end else begin
               e = sbq.pop_front();
               check({e.name, " R1"}, R1, e.r1);
               check({e.name, " R2"}, R2, e.r2);
               check({e.name, " FL"}, FL, e.fl);
               check({e.name, " FLAGS"}, FLAGS, fl2flags(e.fl));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic ld_a(input logic [15:0] v);
      A = v; WA = 1'b1; tick(); WA = 1'b0;
   endtask

   task automatic ld_b(input logic [15:0] v);
      A = v; WB = 1'b1; tick(); WB = 1'b0;
   endtask

   task automatic do_fc(input logic [2:0] code);
      opFL = code; ENADi = 1'b1; tick(); ENADi = 1'b0; tick();
   endtask

   task automatic do_exec(input string name, input logic [5:0] code,
                          input logic [15:0] dval, input logic v,
                          input logic [1:0] wr, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [5:0] efl,
                          input logic fc_en, input logic [2:0] fc);
      exp_t e;
      op = code; A = dval; V = v; WR = wr; opFL = fc; ENADi = fc_en;
      e.name = name; e.r1 = e1; e.r2 = e2; e.fl = efl;
      sbq.push_back(e);
      WD = 1'b1;
      tick();
      WD = 1'b0; ENADi = 1'b0;
      tick();
      check({name, " FINP one cycle"}, FINP, 1'b0);
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst R1", R1, 16'h0000);
      check("rst R2", R2, 16'h0000);
      check("rst FLAGS", FLAGS, 16'h0002);
      check("rst FL", FL, 6'b000000);
      check("rst FINP", FINP, 1'b0);
      check("rst IF", IF, 1'b0);
      @(posedge CLK); #2;
      RST = 1'b1;
      tick();

      // SUB with borrow.
      ld_a(16'hCD0D);
      ld_b(16'hCD3D);
      WR = 2'd1; #1;
      check("load RA", R1, 16'hCD0D);
      check("load RB", R2, 16'hCD3D);
      do_exec("sub", 6'h05, 16'h0000, 1'b0, 2'd0, 16'hFFD0, 16'h0000, 6'b010001, 1'b0, 3'd7);

      // ADD wrapping to zero.
      ld_a(16'h0001);
      ld_b(16'hFFFF);
      do_exec("add", 6'h00, 16'h0000, 1'b0, 2'd0, 16'h0000, 16'h0000, 6'b001111, 1'b0, 3'd7);

      // Load D=4 with an undefined code, then SHL by D.
      ld_a(16'h0F0F);
      do_exec("nopcode", 6'h3F, 16'h0004, 1'b0, 2'd0, 16'h0000, 16'h0000, 6'b001111, 1'b0, 3'd7);
      WR = 2'd2; #1;
      check("D loaded", R1, 16'h0004);
      do_exec("shl by D", 6'h0C, 16'h0004, 1'b1, 2'd0, 16'hF0F0, 16'h0000, 6'b110110, 1'b0, 3'd7);

      // MUL16.
      ld_a(16'h1234);
      ld_b(16'h0100);
      do_exec("mul16", 6'h21, 16'h0000, 1'b0, 2'd0, 16'h3400, 16'h0012, 6'b100011, 1'b0, 3'd7);

      // Flag-control instructions.
      do_fc(3'd4);
      check("STD", FLAGS, 16'h0C07);
      do_fc(3'd3);
      check("CLD", FLAGS, 16'h0807);
      do_fc(3'd6);
      check("STI IF", IF, 1'b1);
      do_fc(3'd5);
      check("CLI IF", IF, 1'b0);
      do_fc(3'd0);
      check("CLC", FLAGS, 16'h0806);
      do_fc(3'd2);
      check("CMC", FLAGS, 16'h0807);
      do_fc(3'd0);
      do_fc(3'd1);
      check("STC", FL, 6'b100011);

      // ADC 0+0 with CF=1, observed through WR=3.
      ld_a(16'h0000);
      ld_b(16'h0000);
      do_exec("adc wr3", 6'h02, 16'h0000, 1'b0, 2'd3, 16'h0002, 16'h0001, 6'b000000, 1'b0, 3'd7);
      WR = 2'd0; #1;
      check("adc RL", R1, 16'h0001);

      // ROR by one: rotates touch only CF/OF.
      ld_a(16'h0001);
      do_exec("ror", 6'h09, 16'h0000, 1'b0, 2'd0, 16'h8000, 16'h0000, 6'b100001, 1'b0, 3'd7);

      // Shift with D=0: nothing changes.
      do_exec("shl cnt0", 6'h0C, 16'h0000, 1'b1, 2'd0, 16'h8000, 16'h0000, 6'b100001, 1'b0, 3'd7);

      // NEG of zero: CF clear, ZF set.
      ld_a(16'h0000);
      do_exec("neg0", 6'h29, 16'h0000, 1'b0, 2'd0, 16'h0000, 16'h0000, 6'b001010, 1'b0, 3'd7);

      // CMP leaves RL alone.
      ld_a(16'h0003);
      ld_b(16'h0005);
      do_exec("cmp", 6'h07, 16'h0000, 1'b0, 2'd0, 16'h0000, 16'h0000, 6'b010101, 1'b0, 3'd7);

      // CWD sign-extends into RH, flags untouched.
      ld_a(16'h8000);
      do_exec("cwd", 6'h2D, 16'h0000, 1'b0, 2'd0, 16'h8000, 16'hFFFF, 6'b010101, 1'b0, 3'd7);

      // XOR with STC on the same edge: STC wins over the cleared CF.
      ld_a(16'h00FF);
      ld_b(16'h00FF);
      do_exec("xor+stc", 6'h06, 16'h0000, 1'b0, 2'd0, 16'h0000, 16'h0000, 6'b001011, 1'b1, 3'd1);

      // CBW.
      ld_a(16'h0080);
      do_exec("cbw", 6'h2C, 16'h0000, 1'b0, 2'd0, 16'hFF80, 16'h0000, 6'b001011, 1'b0, 3'd7);

      tick();
      tick();
      check("scoreboard drained", sbq.size(), 0);

      // Asynchronous reset right after an execute edge.
      op = 6'h00; A = 16'h5555; WA = 1'b1; WB = 1'b1; WD = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      WA = 1'b0; WB = 1'b0; WD = 1'b0;
      WR = 2'd1; #1;
      check("mid rst RA", R1, 16'h0000);
      check("mid rst RB", R2, 16'h0000);
      check("mid rst FLAGS", FLAGS, 16'h0002);
      check("mid rst FINP", FINP, 1'b0);
      WR = 2'd0; #1;
      check("mid rst RL", R1, 16'h0000);
      WR = 2'd2; #1;
      check("mid rst D", R1, 16'h0000);
      tick();
      RST = 1'b1;
      tick();
      check("final scoreboard", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

16-bit 8086-style arithmetic/logic unit with internal operand, count and flag registers. Operands are loaded over the shared 16-bit `A` bus by write strobes. Each execute strobe performs one operation, selected by `op`, and updates a 16-bit 8086-layout FLAGS register. `WR` multiplexes results, operands or flags onto `R1`/`R2`; a separate strobe applies flag-control instructions (CLC/STC/...).

## Interface
- No parameters.
- `CLK` in 1: single clock, rising-edge.
- `RST` in 1: reset, asynchronous, active-low.
- `A` in 16: data bus for operand, count and execute loads.
- `V` in 1: shift/rotate count source; 0 = count 1, 1 = count from register D.
- `op` in 6: operation code.
- `WA` in 1: load register RA from `A`.
- `WB` in 1: load register RB from `A`.
- `WD` in 1: load register D from `A` and execute `op`.
- `ENADi` in 1: execute the flag-control instruction selected by `opFL`.
- `WR` in 2: output select.
- `opFL` in 3: flag-control code.
- `R1` out 16: primary output.
- `R2` out 16: secondary output.
- `FLAGS` out 16: full flag register.
- `FL` out 6: status flags {OF,SF,ZF,AF,PF,CF}.
- `FINP` out 1: operation-done pulse.
- `IF` out 1: FLAGS[9].

## Operation
- FLAGS layout: CF0, bit1 always 1, PF2, AF4, ZF6, SF7, TF8, IF9, DF10, OF11; all other bits 0.
- Operation codes:
  - 0x00 ADD, 0x01 OR, 0x02 ADC, 0x03 SBB, 0x04 AND, 0x05 SUB, 0x06 XOR, 0x07 CMP: RA op RB, 16-bit.
  - 0x08 ROL, 0x09 ROR, 0x0A RCL, 0x0B RCR, 0x0C SHL, 0x0D SHR, 0x0E SAL (=SHL), 0x0F SAR: shift or rotate RA.
  - 0x20 MUL8: RA[7:0]×RB[7:0] unsigned, 16-bit product in RL.
  - 0x21 MUL16: RA×RB unsigned, 32-bit product in {RH,RL}.
  - 0x28 NOT, 0x29 NEG, 0x2C CBW, 0x2D CWD: operate on RA.
- Any other code: RL, RH and FLAGS unchanged; FINP still pulses.
- Result registers RL and RH. RH = 0 for every operation except MUL16 and CWD.
- Arithmetic flags (ADD/ADC/SUB/SBB/CMP/NEG):
  - CF = carry out, or borrow for subtraction.
  - AF = carry or borrow out of bit 3.
  - OF = signed overflow.
  - SF = bit 15; ZF = result == 0; PF = even parity of result[7:0].
- CMP updates flags only; RL is unchanged.
- Logic ops (OR/AND/XOR): CF = OF = AF = 0; SF/ZF/PF from result.
- Shifts and rotates:
  - Count = 1 if V=0, else D[4:0].
  - Count 0: no change to RL or flags.
  - CF = last bit shifted out.
  - OF uses the count-1 rule (MSB XOR CF for left operations; original MSB-related rule for right operations), applied for every count.
  - Shifts update SF/ZF/PF; rotates touch only CF and OF.
- MUL: CF = OF = (upper half ≠ 0); SF/ZF/PF from the low word; AF = 0.
- NOT, CBW and CWD leave flags unchanged.
- NEG: result 0−RA; CF = (RA ≠ 0).
- opFL codes: 0 CLC, 1 STC, 2 CMC, 3 CLD, 4 STD, 5 CLI, 6 STI, 7 NOP.
- Output mux:
  - WR=0: R1 = RL, R2 = RH.
  - WR=1: R1 = RA, R2 = RB.
  - WR=2: R1 = D, R2 = 0.
  - WR=3: R1 = FLAGS, R2 = RL.

## Timing
- Reset (RST low, asynchronous): RA = RB = D = RL = RH = 0, FLAGS = 0x0002, FINP = 0, edge-detect history cleared.
- WA, WB and the D load are level loads: sampled on every rising edge while high.
- WD execution is edge-triggered: executes once on the first rising edge at which WD is sampled high after being low.
  - That edge loads D and registers RL/RH/FLAGS.
  - The operation uses the pre-edge RA, RB and D, so a simultaneous WA or WB does not affect it.
  - Shifts with V=1 therefore use the previous D.
- FINP is high for exactly the one cycle following an execute edge.
- ENADi is edge-triggered in the same way.
  - If it coincides with an execute edge, the flag-control instruction is applied after the operation's flag update.
- R1, R2, FL and IF are combinational from registers and WR.

## Structure
- Package `alu_pkg`: op enum, opFL enum, FLAGS bit-position constants.
- Sub-module `alu_shifter`: combinational shift/rotate unit with CF/OF generation; everything else in the top level.

## Test plan
- RA=0xCD0D, RB=0xCD3D, op=SUB, WD pulse, WR=0 -> R1=0xFFD0, FINP high for 1 cycle; FL: CF=1, SF=1, ZF=0, OF=0, AF=0, PF=0.
- RA=0x0001, RB=0xFFFF, op=ADD -> R1=0x0000; CF=1, ZF=1, AF=1, PF=1, OF=0.
- RA=0x0F0F, D loaded with 4 via a NOP-code WD pulse, then op=SHL, V=1, WD pulse -> R1=0xF0F0, CF=0.
- RA=0x1234, RB=0x0100, op=MUL16 -> R2=0x0012, R1=0x3400, CF=OF=1.
- ENADi with opFL=STC, then op=ADC with 0+0 -> R1=0x0001, CF=0; WR=3 -> R1=FLAGS.
- Assert RST low mid-operation -> all registers at reset values immediately, FLAGS=0x0002.
